// File: rtl/ov7670_sccb_config.sv
// OV7670 register-initialisation sequencer: walks a {reg, value} ROM and issues SCCB writes.
// Optional NACK retry/skip behaviour is enabled with `define SCCB_CFG_NACK_RETRY_EN.
module ov7670_sccb_config #(
  parameter int unsigned IP_CLK_FREQ = 50000000,
  parameter int unsigned I2C_FREQ    = 100000,
  parameter logic [7:0]  DEV_WR_ID   = 8'h42,
  parameter int unsigned POWERUP_MS  = 10,
  parameter int unsigned ROM_AW      = 8,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cfg_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_i2c_start,
  output logic              o_i2c_stop,
  output logic [7:0]        o_i2c_wr_byte,
  input  logic              i_i2c_tx_done,
  input  logic              i_i2c_ack,
  output logic              o_cfg_busy,
  output logic              o_cfg_done,
  output logic              o_nack_err,
  output logic [ROM_AW-1:0] o_entry_cnt
);

  localparam int unsigned CYC_PER_MS = IP_CLK_FREQ / 1000;
  localparam int unsigned PWR_CYC    = POWERUP_MS * CYC_PER_MS;
  localparam int unsigned DLY_CYC    = 10 * CYC_PER_MS;
  localparam int unsigned GAP_CYC    = 2 * IP_CLK_FREQ / I2C_FREQ;
  localparam int unsigned TW         = 32;
  localparam logic [TW-1:0] PWR_LOAD = TW'(PWR_CYC - 1);
  localparam logic [TW-1:0] DLY_LOAD = TW'(DLY_CYC - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYC - 1);

  // Timers are loaded with N-1, so every count must be at least one cycle.
  if (ROM_AW < 1 || IP_CLK_FREQ < 1000 || POWERUP_MS == 0 || GAP_CYC == 0 || MAX_RETRY > 255)
  begin : g_bad_param
    $error("ov7670_sccb_config: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, FETCH, DECODE, START, XFER, GAP, DELAY, DONE
  } state_t;

  state_t              state, state_d;
  logic [TW-1:0]       timer, timer_d;
  logic [ROM_AW-1:0]   rom_addr, rom_addr_d, entry_cnt, entry_cnt_d;
  logic [7:0]          reg_addr, reg_addr_d, reg_val, reg_val_d, wr_byte, wr_byte_d;
  logic [1:0]          byte_idx, byte_idx_d;
  logic                start, start_d, stop, stop_d, busy, busy_d, done, done_d;
  logic                nack, nack_d, last, last_d, adv;
`ifdef SCCB_CFG_NACK_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0]       retry, retry_d;
  logic                txn_nack, txn_nack_d;
`endif

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= PWR_WAIT;
      timer     <= PWR_LOAD;
      rom_addr  <= '0;
      entry_cnt <= '0;
      reg_addr  <= '0;
      reg_val   <= '0;
      wr_byte   <= DEV_WR_ID;
      byte_idx  <= '0;
      start     <= 1'b0;
      stop      <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      nack      <= 1'b0;
      last      <= 1'b0;
`ifdef SCCB_CFG_NACK_RETRY_EN
      retry     <= '0;
      txn_nack  <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      rom_addr  <= rom_addr_d;
      entry_cnt <= entry_cnt_d;
      reg_addr  <= reg_addr_d;
      reg_val   <= reg_val_d;
      wr_byte   <= wr_byte_d;
      byte_idx  <= byte_idx_d;
      start     <= start_d;
      stop      <= stop_d;
      busy      <= busy_d;
      done      <= done_d;
      nack      <= nack_d;
      last      <= last_d;
`ifdef SCCB_CFG_NACK_RETRY_EN
      retry     <= retry_d;
      txn_nack  <= txn_nack_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    timer_d     = timer;
    rom_addr_d  = rom_addr;
    entry_cnt_d = entry_cnt;
    reg_addr_d  = reg_addr;
    reg_val_d   = reg_val;
    wr_byte_d   = wr_byte;
    byte_idx_d  = byte_idx;
    stop_d      = stop;
    nack_d      = nack;
    last_d      = last;
    adv         = 1'b1;
`ifdef SCCB_CFG_NACK_RETRY_EN
    retry_d     = retry;
    txn_nack_d  = txn_nack;
`endif

    case (state)
      IDLE, DONE: begin
        if (i_cfg_start) begin
          state_d     = PWR_WAIT;
          timer_d     = PWR_LOAD;
          rom_addr_d  = '0;
          entry_cnt_d = '0;
          nack_d      = 1'b0;
          last_d      = 1'b0;
          wr_byte_d   = DEV_WR_ID;
`ifdef SCCB_CFG_NACK_RETRY_EN
          retry_d     = '0;
`endif
        end
      end
      PWR_WAIT: begin
        if (timer == '0) state_d = FETCH;
        else             timer_d = timer - TW'(1);
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (i_rom_data == 16'hFFFF) begin
          state_d = DONE;
        end else if (i_rom_data == 16'hFFF0) begin
          state_d = DELAY;
          timer_d = DLY_LOAD;
        end else begin
          state_d    = START;
          reg_addr_d = i_rom_data[15:8];
          reg_val_d  = i_rom_data[7:0];
          byte_idx_d = 2'd0;
          wr_byte_d  = DEV_WR_ID;
`ifdef SCCB_CFG_NACK_RETRY_EN
          txn_nack_d = 1'b0;
`endif
        end
      end
      START: state_d = XFER;
      XFER: begin
        if (i_i2c_tx_done) begin
          if (i_i2c_ack) nack_d = 1'b1;
`ifdef SCCB_CFG_NACK_RETRY_EN
          if (i_i2c_ack) txn_nack_d = 1'b1;
`endif
          if (byte_idx == 2'd2) begin
            state_d = GAP;
            timer_d = GAP_LOAD;
            stop_d  = 1'b0;
`ifdef SCCB_CFG_NACK_RETRY_EN
            // A NACKed entry is resent MAX_RETRY times, then skipped uncounted.
            if (txn_nack_d && (retry < RW'(MAX_RETRY))) begin
              retry_d = retry + RW'(1);
              adv     = 1'b0;
            end else begin
              retry_d = '0;
              if (!txn_nack_d) entry_cnt_d = entry_cnt + ROM_AW'(1);
            end
`else
            entry_cnt_d = entry_cnt + ROM_AW'(1);
`endif
            if (adv) begin
              if (rom_addr == '1) last_d     = 1'b1;
              else                rom_addr_d = rom_addr + ROM_AW'(1);
            end
          end else begin
            byte_idx_d = byte_idx + 2'd1;
            wr_byte_d  = (byte_idx_d == 2'd1) ? reg_addr : reg_val;
`ifdef SCCB_CFG_NACK_RETRY_EN
            stop_d     = (byte_idx_d == 2'd2) || txn_nack_d;
`else
            stop_d     = (byte_idx_d == 2'd2);
`endif
          end
        end
      end
      GAP: begin
        if (timer == '0) state_d = last ? DONE : FETCH;
        else             timer_d = timer - TW'(1);
      end
      DELAY: begin
        if (timer == '0) begin
          if (rom_addr == '1) begin
            state_d = DONE;
          end else begin
            state_d    = FETCH;
            rom_addr_d = rom_addr + ROM_AW'(1);
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    start_d = (state_d == START);
    busy_d  = !((state_d == IDLE) || (state_d == DONE));
    done_d  = (state_d == DONE);
  end

  assign o_rom_addr    = rom_addr;
  assign o_i2c_start   = start;
  assign o_i2c_stop    = stop;
  assign o_i2c_wr_byte = wr_byte;
  assign o_cfg_busy    = busy;
  assign o_cfg_done    = done;
  assign o_nack_err    = nack;
  assign o_entry_cnt   = entry_cnt;

endmodule

// File: doc/ov7670_sccb_config.md
# ov7670_sccb_config

Register-initialisation sequencer upstream of the I2C/SCCB byte controller. It walks a table of `{register address, value}` pairs held in an external synchronous ROM. For each entry it issues one three-byte SCCB write transaction (device write ID, register address, value) through the controller's start/stop/byte/tx_done handshake. It supports an inline millisecond-delay marker and an end-of-table marker, and raises `o_cfg_done` once the camera is configured.

## Interface
- `IP_CLK_FREQ`, 50000000, system clock frequency in Hz.
- `I2C_FREQ`, 100000, SCL frequency in Hz; used only to size the post-stop gap.
- `DEV_WR_ID`, 8'h42, SCCB device write ID, sent as byte 0.
- `POWERUP_MS`, 10, wait after reset or restart before the first entry is fetched.
- `ROM_AW`, 8, ROM address width.
- `MAX_RETRY`, 3, retries per entry (used only with the macro).

Ports:
- `i_clk` in 1: system clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_cfg_start` in 1: one-cycle pulse; restarts the sequence from ROM address 0. Ignored while `o_cfg_busy`=1.
- `o_rom_addr` out ROM_AW: ROM address.
- `i_rom_data` in 16: `{reg_addr[15:8], value[7:0]}`; valid 1 cycle after `o_rom_addr` changes.
- `o_i2c_start` out 1: one-cycle start pulse to the controller.
- `o_i2c_stop` out 1: stop request to the controller.
- `o_i2c_wr_byte` out 8: byte currently offered to the controller.
- `i_i2c_tx_done` in 1: one-cycle pulse at the ACK bit of each byte.
- `i_i2c_ack` in 1: sampled SDA at the ACK bit; 0 = acknowledged. Meaningful only when `i_i2c_tx_done`=1.
- `o_cfg_busy` out 1: sequence in progress.
- `o_cfg_done` out 1: table complete; held until restart or reset.
- `o_nack_err` out 1: sticky; at least one NACK seen since the last start.
- `o_entry_cnt` out ROM_AW: number of register writes completed.

## Operation
- States: IDLE, PWR_WAIT, FETCH, DECODE, START, XFER, GAP, DELAY, DONE.
- After reset the FSM enters PWR_WAIT directly; the sequence is automatic at power-up.
  - `i_cfg_start` in IDLE or DONE clears `o_cfg_done`, `o_nack_err`, `o_entry_cnt` and `o_rom_addr`, then enters PWR_WAIT.
- PWR_WAIT: counts `POWERUP_MS*(IP_CLK_FREQ/1000)` cycles, then goes to FETCH.
- FETCH: one cycle for the ROM read, then DECODE.
- DECODE on `i_rom_data`:
  - 16'hFFFF (end marker) -> DONE.
  - 16'hFFF0 (delay marker) -> DELAY for 10 ms, then `o_rom_addr`+1 and FETCH.
  - Anything else -> latch the entry, set byte index to 0, go to START.
- START: `o_i2c_start`=1 for exactly one cycle with `o_i2c_wr_byte`=DEV_WR_ID, then XFER.
- XFER:
  - `o_i2c_wr_byte` is selected combinationally by byte index: 0 = DEV_WR_ID, 1 = reg_addr, 2 = value.
  - Each `i_i2c_tx_done` advances the byte index, so the next byte is stable in the cycle after tx_done, when the controller loads it.
  - `o_i2c_stop`=1 whenever byte index = 2.
  - The tx_done for byte 2 goes to GAP, increments `o_entry_cnt` and `o_rom_addr`, and deasserts stop the following cycle.
- GAP: waits `2*IP_CLK_FREQ/I2C_FREQ` cycles (covers the controller's STOP1/STOP2 and bus-free time), then FETCH.
- DONE: `o_cfg_done`=1 and `o_cfg_busy`=0.
- `o_nack_err` sets on any tx_done with `i_i2c_ack`=1.
- ROM address wrap: if `o_rom_addr` reaches 2^ROM_AW-1 without an end marker, that entry is the last processed and the FSM goes to DONE. The address never wraps to 0.

## Timing
- Reset values:
  - all strobes 0;
  - `o_i2c_wr_byte`=DEV_WR_ID;
  - `o_rom_addr`=0, `o_entry_cnt`=0;
  - `o_cfg_busy`=1 (state PWR_WAIT), `o_cfg_done`=0, `o_nack_err`=0.
- DECODE to `o_i2c_start`: 1 cycle.
- Entry-to-entry time is bounded by the controller, plus GAP plus 3 cycles (FETCH, DECODE, START).
- `o_i2c_start` is never asserted while `o_i2c_stop`=1 or outside START.
- tx_done while not in XFER is ignored.
- `i_cfg_start` while busy is ignored (no queueing).
- Reset mid-transaction: outputs return to reset values asynchronously. The controller is reset by the same `i_rstn`.

## Configuration
- `SCCB_CFG_NACK_RETRY_EN` defined:
  - A NACK on any byte sets `o_nack_err` and completes the transaction with stop (stop forced from that point).
  - After GAP the same entry is re-fetched and resent, up to MAX_RETRY times.
  - After that the entry is skipped; `o_entry_cnt` counts only acknowledged writes.
- Undefined: ack is don't-care (SCCB behaviour). A NACK only sets `o_nack_err`, the sequence continues, and `o_entry_cnt` counts every write.

## Test plan
- Reset, ROM = {16'h1280, 16'hFFFF}:
  - after 10 ms, bytes 42, 12, 80 are sent;
  - stop is high only during byte 2;
  - `o_entry_cnt`=1, `o_cfg_done`=1.
- ROM = {16'h1100, 16'hFFF0, 16'h6B0A, 16'hFFFF}: the second start occurs ≥10 ms + GAP after the first stop; `o_entry_cnt`=2.
- Controller model NACKs byte 1 of entry 0:
  - macro off: `o_nack_err`=1, 2 entries written, done;
  - macro on: entry 0 is sent 1+MAX_RETRY=4 times, then skipped, and `o_entry_cnt` excludes it.
- `i_cfg_start` pulsed mid-sequence: no effect. Pulsed after done: done clears, PWR_WAIT re-entered, table replayed from address 0.
- `i_rstn` low during byte 1: `o_i2c_start`/`o_i2c_stop` drop immediately; after release the sequence restarts from address 0.
- ROM with no end marker, ROM_AW=2: four entries are written, then done; `o_rom_addr` holds at 3.
